// File: rtl/mole_pkg.sv
// Shared types and constants for the mole_judge game-round controller.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2
    } state_t;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_judge_if.sv
// Player/score-side signal bundle of mole_judge: game enable, buttons and judged results.
interface mole_judge_if #(
    parameter int NUM_HOLES = 4
);
    logic                 start;
    logic [NUM_HOLES-1:0] btn;
    logic [NUM_HOLES-1:0] mole;
    logic                 out;
    logic                 miss;
    logic                 busy;

    modport master (output start, btn, input mole, out, miss, busy);
    modport slave  (input start, btn, output mole, out, miss, busy);
endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer per button followed by a previous-value flop for 0->1 detection.
module btn_edge_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] btn_p0;
    logic [WIDTH-1:0] btn_p1;
    logic [WIDTH-1:0] btn_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            btn_p2 <= '0;
        end else begin
            btn_p0 <= din;
            btn_p1 <= btn_p0;
            btn_p2 <= btn_p1;
        end
    end

    // p1 is the settled value, p2 the value one cycle earlier
    assign rise = btn_p1 & ~btn_p2;

endmodule

// File: rtl/mole_judge.sv
// Whack-a-mole round controller: pops a pseudo-random mole and judges presses into hit/miss pulses.
module mole_judge
    import mole_pkg::*;
#(
    parameter int         NUM_HOLES  = 4,
    parameter int         UP_CYCLES  = 50,
    parameter int         GAP_CYCLES = 20,
    parameter logic [7:0] LFSR_SEED  = LFSR_SEED_DEF
) (
    input logic         clk,
    input logic         reset,
    mole_judge_if.slave bus
);

    localparam int HW      = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
    localparam int CNT_MAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] UP_LOAD  = CW'(UP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    state_t               state, state_nx;
    logic [CW-1:0]        gap_cnt, gap_nx;
    logic [CW-1:0]        up_cnt, up_nx;
    logic [HW-1:0]        hole, hole_nx;
    logic [HW-1:0]        cand;
    logic [7:0]           lfsr;
    logic [NUM_HOLES-1:0] mole_q, mole_nx;
    logic                 out_q, out_nx;
    logic                 miss_q, miss_nx;
    logic                 busy_q;
    logic [NUM_HOLES-1:0] rise;
    logic                 lit_rise;
    logic                 wrong_rise;

    btn_edge_sync #(.WIDTH(NUM_HOLES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.btn),
        .rise  (rise)
    );

    // mole_q is the one-hot of the lit hole whenever the FSM is in UP
    assign lit_rise   = |(rise & mole_q);
    assign wrong_rise = |(rise & ~mole_q);

    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        up_nx    = up_cnt;
        hole_nx  = hole;
        out_nx   = 1'b0;
        miss_nx  = 1'b0;
        mole_nx  = '0;
        cand     = lfsr[HW-1:0];

        if (!bus.start) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = GAP;
                    gap_nx   = GAP_LOAD;
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state_nx = UP;
                        up_nx    = UP_LOAD;
                        hole_nx  = (cand == hole) ? cand + 1'b1 : cand;
                    end else begin
                        gap_nx = gap_cnt - 1'b1;
                    end
                end
                UP: begin
                    if (lit_rise) begin
                        out_nx   = 1'b1;
                        state_nx = GAP;
                        gap_nx   = GAP_LOAD;
                    end else begin
                        miss_nx = wrong_rise;
                        if (up_cnt == '0) begin
                            miss_nx  = 1'b1;
                            state_nx = GAP;
                            gap_nx   = GAP_LOAD;
                        end else begin
                            up_nx = up_cnt - 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        if (state_nx == UP) begin
            mole_nx[hole_nx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            up_cnt  <= '0;
            hole    <= '0;
            lfsr    <= LFSR_SEED;
            mole_q  <= '0;
            out_q   <= 1'b0;
            miss_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_nx;
            up_cnt  <= up_nx;
            hole    <= hole_nx;
            if (state != IDLE) begin
                lfsr <= lfsr_step(lfsr);
            end
            mole_q  <= mole_nx;
            out_q   <= out_nx;
            miss_q  <= miss_nx;
            busy_q  <= (state_nx != IDLE);
        end
    end

    assign bus.mole = mole_q;
    assign bus.out  = out_q;
    assign bus.miss = miss_q;
    assign bus.busy = busy_q;

endmodule

// File: doc/mole_judge.md
# mole_judge

Game-round controller that sits directly upstream of the score counter. It pops one mole at a time in a pseudo-random hole and judges player button presses against it. Each correct press produces the one-cycle `out` hit pulse that the score counter increments on; each timeout or wrong-hole press produces a `miss` pulse.

## Interface
- `NUM_HOLES`, default 4: number of holes/buttons; power of two, 2..8.
- `UP_CYCLES`, default 50: cycles a mole stays up, ≥2.
- `GAP_CYCLES`, default 20: cycles between moles, ≥1.
- `LFSR_SEED`, default 8'hA5: LFSR reset value, nonzero.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: game enable (level); low forces IDLE.
- `btn`, input, NUM_HOLES: raw, asynchronous player buttons, one per hole.
- `mole`, output, NUM_HOLES: one-hot lit hole; all zero when no mole is up.
- `out`, output, 1: one-cycle hit pulse to the score counter.
- `miss`, output, 1: one-cycle miss pulse.
- `busy`, output, 1: high in any state except IDLE.

## Operation
- States: IDLE, GAP, UP.
- IDLE: `mole`=0.
  - `start`=1 → GAP, with the gap counter loaded to GAP_CYCLES-1.
- GAP:
  - `mole`=0.
  - The counter decrements each cycle.
  - At 0 → UP: lit hole selected, up counter loaded to UP_CYCLES-1.
- UP: `mole` = one-hot of the lit hole.
  - Rising edge on the lit hole's button → `out` pulse, → GAP.
  - Rising edge on any other button with no lit-hole edge in the same cycle → `miss` pulse; stay in UP, counter continues.
  - Counter reaches 0 with no lit-hole edge → `miss` pulse, → GAP.
- Hole selection:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4; advances every cycle the block is not in IDLE.
  - Candidate = low log2(NUM_HOLES) bits of the LFSR.
  - If the candidate equals the previous lit hole, use (candidate+1) mod NUM_HOLES. No hole is ever lit twice in a row.
- Priority within one cycle:
  1. `start`=0 wins over everything: → IDLE, `mole`=0, no `out` or `miss`.
  2. A lit-hole edge wins over a wrong-hole edge and over timeout: `out` only, never `miss`.
- `out` and `miss` are never high together, and each is high for exactly one cycle per event.
- Button holding: a held button counts once; only 0→1 transitions after synchronization count.

## Timing
- Reset values:
  - `mole`=0, `out`=0, `miss`=0, `busy`=0.
  - State IDLE; LFSR = LFSR_SEED; previous hole = 0; sync and edge flops = 0.
- Reset mid-round: all outputs clear immediately (asynchronous). No pulse is emitted on the way out.
- Button path:
  - 2-flop synchronizer, then a previous-value flop; edge = sync2 & ~prev.
  - `btn` high at clock edge k → `out` high in the cycle after edge k+2. Latency is 3 edges.
- `start` rise at edge k → GAP from edge k+1.
- `mole` asserted exactly GAP_CYCLES cycles after entering GAP.
- `mole` stays up for exactly UP_CYCLES cycles on timeout.
- All outputs are registered; there are no combinational input→output paths.
- Counter width: $clog2(max(UP_CYCLES, GAP_CYCLES)). Counters never wrap; the 0 terminal count forces a transition.

## Structure
- Package `mole_pkg`: state enum (IDLE, GAP, UP), LFSR tap mask constant, default seed constant.
- Sub-module `btn_edge_sync`, parameterized by width: 2-flop synchronizer plus rising-edge detect per bit. It uses the same `clk` and `reset`.
- Top level holds the FSM, the two counters, the LFSR and the previous-hole register.

## Test plan
All scenarios use NUM_HOLES=4, UP_CYCLES=8, GAP_CYCLES=4.
1. Reset, then `start`=1 → `mole`=0 for 4 cycles, then exactly one bit of `mole` high; `busy`=1 from the first cycle after start.
2. Press the button matching `mole` → `out` high for exactly 1 cycle, 3 edges later. `mole` clears and the next mole appears 4 cycles later, in a different hole. Holding the button gives no second `out`.
3. No press → `mole` held for 8 cycles, then `miss`=1 for 1 cycle and `mole`=0. `out` never asserts.
4. Wrong button pressed at up-cycle 2 → one `miss` pulse; mole stays lit. A correct press at cycle 5 then yields `out`=1 and a return to GAP.
5. Correct and wrong buttons rise in the same cycle, and separately a correct press edge lands on the terminal up cycle → `out`=1, `miss`=0 in both cases.
6. `start` dropped while UP, and separately `reset` pulsed low mid-GAP → `mole`=0 and `busy`=0 immediately (reset) or next edge (start); no `out` or `miss`. Restart replays the LFSR sequence from seed 8'hA5 identically.
